// File: rtl/fsk_nco_mod_pkg.sv
// Shared modem constants: sample format, PN7 generator taps and the bit window
// length that the demodulator also uses.
package fsk_nco_mod_pkg;

  localparam int unsigned SAMPLE_W        = 11;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 11'd1024;
  localparam int unsigned AMP_W           = 10;
  localparam logic [AMP_W-1:0] AMP        = 10'd1023;
  localparam int unsigned PHASE_W         = 10;
  localparam int unsigned QROM_DEPTH      = 256;

  localparam int unsigned PN_LEN    = 7;
  localparam int unsigned PN7_TAP_A = 6;
  localparam int unsigned PN7_TAP_B = 5;

  localparam int unsigned DEFAULT_BIT_LEN = 2048;

  typedef struct packed {
    logic code;
    logic strobe;
  } pipe_tag_t;

  // x^7 + x^6 + 1, shifting towards the MSB; the transmitted bit is s[0].
  function automatic logic [PN_LEN-1:0] pn7_next(input logic [PN_LEN-1:0] s);
    return {s[PN_LEN-2:0], s[PN7_TAP_A] ^ s[PN7_TAP_B]};
  endfunction

endpackage

// File: rtl/sine_qrom.sv
// Quarter-wave sine ROM, 256 x 10, registered read. Contents are
// round(1023*sin(pi*k/512)) built at elaboration time.
module sine_qrom
  import fsk_nco_mod_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       addr,
  output logic [AMP_W-1:0] data
);

  // Taylor series to x^17 keeps the error far below half an LSB up to pi/2.
  function automatic logic [QROM_DEPTH*AMP_W-1:0] gen_table();
    logic [QROM_DEPTH*AMP_W-1:0] r;
    real x;
    real term;
    real s;
    r = '0;
    for (int unsigned k = 0; k < QROM_DEPTH; k++) begin
      x    = 3.14159265358979323846 * real'(k) / 512.0;
      s    = x;
      term = x;
      for (int unsigned n = 1; n < 9; n++) begin
        term = -term * x * x / real'((2 * n) * (2 * n + 1));
        s    = s + term;
      end
      r[k*AMP_W +: AMP_W] = AMP_W'($rtoi(1023.0 * s + 0.5));
    end
    return r;
  endfunction

  localparam logic [QROM_DEPTH*AMP_W-1:0] TABLE = gen_table();

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= TABLE[addr*AMP_W +: AMP_W];
    end
  end

endmodule

// File: rtl/fsk_nco_mod.sv
// Continuous-phase 2FSK modulator: PN7 bit source, NCO phase accumulator and
// quarter-wave sine lookup, with code/bit_strobe aligned to the sample.
module fsk_nco_mod
  import fsk_nco_mod_pkg::*;
#(
  parameter int unsigned       ACC_W   = 16,
  parameter logic [ACC_W-1:0]  F0      = 16'd128,
  parameter logic [ACC_W-1:0]  F1      = 16'd512,
  parameter int unsigned       BIT_LEN = DEFAULT_BIT_LEN,
  parameter logic [PN_LEN-1:0] PN_SEED = 7'h7F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [SAMPLE_W-1:0] data_module,
  output logic                code,
  output logic                bit_strobe
);

  localparam int unsigned CNT_W = $clog2(BIT_LEN);

  logic [CNT_W-1:0]    bit_cnt;
  logic [ACC_W-1:0]    acc;
  logic [PN_LEN-1:0]   lfsr;
  logic [PHASE_W-1:0]  phase;
  logic [1:0]          quad;
  logic [7:0]          idx;
  logic [7:0]          rom_addr;
  logic [AMP_W-1:0]    rom_data;
  logic                s1_neg;
  logic                s1_peak;
  pipe_tag_t           s1_tag;
  logic [SAMPLE_W-1:0] mag;

  // S0: bit timer, PN source and phase accumulator (never cleared per bit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      acc     <= '0;
      lfsr    <= PN_SEED;
    end else if (en) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      acc     <= acc + (lfsr[0] ? F1 : F0);
      if (&bit_cnt) begin
        lfsr <= pn7_next(lfsr);
      end
    end
  end

  assign phase = acc[ACC_W-1 -: PHASE_W];
  assign quad  = phase[9:8];
  assign idx   = phase[7:0];

  // Odd quadrants read the table mirrored; 256-i wraps to 0 at i=0, which is
  // the peak and is substituted with AMP one stage later.
  assign rom_addr = quad[0] ? 8'(8'd0 - idx) : idx;

  sine_qrom u_qrom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  assign mag = {1'b0, s1_peak ? AMP : rom_data};

  // S1 sign/peak/tag alongside the ROM read, then S2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_neg      <= 1'b0;
      s1_peak     <= 1'b0;
      s1_tag      <= '{code: PN_SEED[0], strobe: 1'b0};
      data_module <= MIDSCALE;
      code        <= PN_SEED[0];
      bit_strobe  <= 1'b0;
    end else if (en) begin
      s1_neg      <= quad[1];
      s1_peak     <= quad[0] && (idx == '0);
      s1_tag      <= '{code: lfsr[0], strobe: (bit_cnt == '0)};
      data_module <= s1_neg ? (MIDSCALE - mag) : (MIDSCALE + mag);
      code        <= s1_tag.code;
      bit_strobe  <= s1_tag.strobe;
    end
  end

endmodule

// File: tb/tb_fsk_nco_mod.sv
// Randomised-enable bench for fsk_nco_mod against an ideal-sine reference of
// the continuous-phase FSK waveform.
module tb_fsk_nco_mod;

  localparam int unsigned BIT_LEN = 2048;
  localparam int unsigned F0      = 128;
  localparam int unsigned F1      = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] data_module;
  logic        code;
  logic        bit_strobe;

  fsk_nco_mod #(
    .ACC_W   (16),
    .F0      (16'd128),
    .F1      (16'd512),
    .BIT_LEN (BIT_LEN),
    .PN_SEED (7'h7F)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data_module (data_module),
    .code        (code),
    .bit_strobe  (bit_strobe)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // PN bit b(t) = pn_arr[t+6]; seed 7F means b(-6..0)=1, b(t+1)=b(t-5)^b(t-6).
  bit pn_arr[0:139];

  function automatic int pn_bit(input int t);
    return int'(pn_arr[(t % 127) + 6]);
  endfunction

  function automatic int ref_sample(input int unsigned a);
    real s;
    int  m;
    s = $sin(2.0 * 3.14159265358979323846 * real'(a >> 6) / 1024.0);
    m = $rtoi(1023.0 * (s < 0.0 ? -s : s) + 0.5);
    return (s < 0.0) ? 1024 - m : 1024 + m;
  endfunction

  int          m_edges;
  int unsigned m_acc;
  int          m_k;
  int          exp_dm, exp_code, exp_strobe;
  int          out_k;

  bit first_run = 1'b1;
  int first_strobe_edge = -1;
  int codes[$];
  int prev_dm = 1024;
  int up0 = 0, dn0 = 0, cr1 = 0, max_jump1 = 0;

  task automatic model_reset();
    m_edges = 0; m_acc = 0; m_k = 0;
    exp_dm = 1024; exp_code = 1; exp_strobe = 0;
    out_k = -1;
    prev_dm = 1024;
    codes.delete();
  endtask

  task automatic model_edge(output bit new_sample);
    int b;
    new_sample = 1'b0;
    m_edges++;
    if (m_edges >= 2) begin
      b          = pn_bit(m_k / int'(BIT_LEN));
      exp_dm     = ref_sample(m_acc);
      exp_code   = b;
      exp_strobe = (m_k % int'(BIT_LEN) == 0) ? 1 : 0;
      m_acc      = (m_acc + (b != 0 ? F1 : F0)) & 32'hFFFF;
      out_k      = m_k;
      m_k++;
      new_sample = 1'b1;
    end
  endtask

  task automatic observe();
    int dm, d;
    dm = int'(data_module);
    if (bit_strobe) begin
      codes.push_back(int'(code));
      if (first_strobe_edge < 0) first_strobe_edge = m_edges;
    end
    if (first_run) begin
      if (out_k == 32) check_eq("wave_peak_k32", dm, 2047);
      if (out_k == 64) check_eq("wave_mid_k64", dm, 1024);
      if (out_k == 96) check_eq("wave_trough_k96", dm, 1);
      if (out_k >= 1 && out_k <= 4096 && prev_dm == 1024) begin
        if ((out_k - 1) < int'(BIT_LEN)) begin
          if (dm > 1024) up0++;
          else if (dm < 1024) dn0++;
        end else if (dm != 1024) begin
          cr1++;
        end
      end
      d = (dm > prev_dm) ? dm - prev_dm : prev_dm - dm;
      if (out_k == int'(BIT_LEN)) check_eq("boundary_jump_le_51", (d <= 51) ? 1 : 0, 1);
      if (out_k > int'(BIT_LEN) && out_k < 2 * int'(BIT_LEN) && d > max_jump1) max_jump1 = d;
    end
    prev_dm = dm;
  endtask

  task automatic step(input logic e);
    bit ns;
    en = e;
    @(posedge clk);
    #1;
    ns = 1'b0;
    if (e) model_edge(ns);
    check_eq("data_module", int'(data_module), exp_dm);
    check_eq("code", int'(code), exp_code);
    check_eq("bit_strobe", int'(bit_strobe), exp_strobe);
    if (ns) observe();
  endtask

  task automatic run_until(input int target, input int budget);
    int c = 0;
    while (out_k < target && c < budget) begin
      step($urandom_range(0, 7) != 0);
      c++;
    end
    if (c == budget) check_eq("run_budget_sample_index", out_k, target);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_data_module"}, int'(data_module), 1024);
    check_eq({tag, "_code"}, int'(code), 1);
    check_eq({tag, "_bit_strobe"}, int'(bit_strobe), 0);
  endtask

  // Asynchronous reset placed mid-cycle, checked before the next clock edge.
  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1 check_reset_values({tag, "_hold"});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_pn[8] = '{1, 0, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 7; i++) pn_arr[i] = 1'b1;
    for (int i = 7; i < 140; i++) pn_arr[i] = pn_arr[i-6] ^ pn_arr[i-7];

    model_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1 check_reset_values("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) step(1'b1);
    check_eq("first_strobe_edge", first_strobe_edge, 2);

    run_until(int'(BIT_LEN) + 700, 4000);
    repeat (37) step(1'b0);
    run_until(7 * int'(BIT_LEN) + 10, 20000);

    check_eq("pn_strobe_count", codes.size(), 8);
    for (int i = 0; i < 8 && i < codes.size(); i++)
      check_eq($sformatf("pn_order_%0d", i), codes[i], exp_pn[i]);
    check_eq("bit0_up_crossings", up0, 16);
    check_eq("bit0_down_crossings", dn0, 16);
    check_eq("bit1_crossings", cr1, 8);
    check_eq("bit1_max_jump_le_13", (max_jump1 <= 13) ? 1 : 0, 1);

    first_run = 1'b0;
    async_reset("reset_after_run");
    run_until(3 * int'(BIT_LEN) + 1000, 9000);
    async_reset("reset_mid_bit3");
    run_until(2 * int'(BIT_LEN) + 5, 6000);
    check_eq("restart_strobe_count", codes.size(), 3);
    for (int i = 0; i < 3 && i < codes.size(); i++)
      check_eq($sformatf("restart_pn_%0d", i), codes[i], exp_pn[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
